// File: rtl/ram64_copier_if.sv
// Command and RAM-bus bundle for ram64_copier.
// RAM64_COPIER_CHECKSUM_EN adds the checksum signal to the bundle.
interface ram64_copier_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
);
  logic             start;
  logic [AW-1:0]    src;
  logic [AW-1:0]    dst;
  logic [AW:0]      len;
  logic             busy;
  logic             done;
  logic [AW-1:0]    mem_address;
  logic             mem_load;
  logic [WIDTH-1:0] mem_in;
  logic [WIDTH-1:0] mem_out;
`ifdef RAM64_COPIER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;

  modport slave (
    input  start, src, dst, len, mem_out,
    output busy, done, mem_address, mem_load, mem_in, checksum
  );
  modport master (
    output start, src, dst, len, mem_out,
    input  busy, done, mem_address, mem_load, mem_in, checksum
  );
`else
  modport slave (
    input  start, src, dst, len, mem_out,
    output busy, done, mem_address, mem_load, mem_in
  );
  modport master (
    output start, src, dst, len, mem_out,
    input  busy, done, mem_address, mem_load, mem_in
  );
`endif
endinterface

// File: rtl/ram64_copier.sv
// DMA-style block copier for a 64-word RAM with registered read data.
// Define RAM64_COPIER_CHECKSUM_EN to add a running sum of copied words.
module ram64_copier #(
  parameter int RD_LAT = 1,
  parameter int WIDTH  = 16,
  parameter int AW     = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  ram64_copier_if.slave  bus
);

  localparam int             DEPTH     = 1 << AW;
  localparam logic [2:0]     WAIT_LAST = 3'(RD_LAT - 1);
  localparam logic [AW:0]    LEN_MAX   = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [AW:0]      r_len;
  logic [AW:0]      r_count;
  logic [2:0]       r_wait;
  logic [WIDTH-1:0] r_data;
  logic [AW-1:0]    r_mem_address;
  logic             r_mem_load;
  logic             r_busy;
  logic             r_done;

  logic [AW:0]      w_len_clamped;
  logic [AW:0]      w_count_next;
  logic [AW-1:0]    w_rd_addr_next;
  logic [AW-1:0]    w_wr_addr;

  assign w_len_clamped  = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign w_count_next   = r_count + 1'b1;
  // Address sums truncate to AW bits, giving the wrap from 63 to 0.
  assign w_rd_addr_next = r_src + w_count_next[AW-1:0];
  assign w_wr_addr      = r_dst + r_count[AW-1:0];

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_load    = r_mem_load;
  assign bus.mem_in      = r_data;

`ifdef RAM64_COPIER_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;
  assign bus.checksum = r_checksum;
`endif

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples the pre-edge values; the data register is reset too because it
  // drives mem_in directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_src         <= '0;
      r_dst         <= '0;
      r_len         <= '0;
      r_count       <= '0;
      r_wait        <= '0;
      r_data        <= '0;
      r_mem_address <= '0;
      r_mem_load    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef RAM64_COPIER_CHECKSUM_EN
      r_checksum    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_src   <= bus.src;
            r_dst   <= bus.dst;
            r_len   <= w_len_clamped;
            r_count <= '0;
`ifdef RAM64_COPIER_CHECKSUM_EN
            r_checksum <= '0;
`endif
            if (w_len_clamped == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state       <= S_RD;
              r_busy        <= 1'b1;
              r_mem_address <= bus.src;
            end
          end
        end

        S_RD: begin
          r_state <= S_WAIT;
          r_wait  <= '0;
        end

        S_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_data        <= bus.mem_out;
            r_mem_address <= w_wr_addr;
            r_mem_load    <= 1'b1;
            r_state       <= S_WR;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end

        S_WR: begin
          r_mem_load <= 1'b0;
          r_count    <= w_count_next;
`ifdef RAM64_COPIER_CHECKSUM_EN
          r_checksum <= r_checksum + r_data;
`endif
          if (w_count_next == r_len) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state       <= S_RD;
            r_mem_address <= w_rd_addr_next;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_mem_load <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram64_copier.sv
// Self-checking bench for ram64_copier: behavioural RAM, forward-copy model,
// per-cycle write checker and randomized commands.
module tb_ram64_copier;

  localparam int RD_LAT = 1;
  localparam int WIDTH  = 16;
  localparam int AW     = 6;
  localparam int DEPTH  = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  ram64_copier_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  ram64_copier #(.RD_LAT(RD_LAT), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural RAM with RD_LAT-cycle registered read, plus a preload port.
  logic [WIDTH-1:0] tb_mem [DEPTH];
  logic [WIDTH-1:0] rd_pipe [RD_LAT];
  logic             pre_we = 1'b0;
  logic [AW-1:0]    pre_addr = '0;
  logic [WIDTH-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (bus.mem_load) tb_mem[bus.mem_address] <= bus.mem_in;
    if (pre_we)       tb_mem[pre_addr] <= pre_data;
    rd_pipe[0] <= tb_mem[bus.mem_address];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.mem_out = rd_pipe[RD_LAT-1];

  // Reference model state.
  typedef struct {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } wr_t;

  logic [WIDTH-1:0] gold [DEPTH];
  wr_t              exp_q [$];
  int               n_wr;
  int               n_checks;
  int               n_errors;
`ifdef RAM64_COPIER_CHECKSUM_EN
  logic [WIDTH-1:0] exp_sum;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Forward copy: each word is read after the previous word was written.
  task automatic model_cmd(input int s, input int d, input int l);
    logic [WIDTH-1:0] sh [DEPTH];
    int n;
    sh = gold;
    n = (l > DEPTH) ? DEPTH : l;
`ifdef RAM64_COPIER_CHECKSUM_EN
    exp_sum = '0;
`endif
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.a = AW'((d + i) % DEPTH);
      w.d = sh[(s + i) % DEPTH];
      sh[w.a] = w.d;
      exp_q.push_back(w);
`ifdef RAM64_COPIER_CHECKSUM_EN
      exp_sum = exp_sum + w.d;
`endif
    end
  endtask

  // Compare process: every RAM write must be the next one the model predicts.
  always @(negedge clk) begin
    if (reset_n) begin
      check("done_busy_exclusive", {31'd0, bus.done & bus.busy}, 32'd0);
      if (bus.mem_load) begin
        n_wr++;
        check("write_while_busy", {31'd0, bus.busy}, 32'd1);
        check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          wr_t w;
          w = exp_q.pop_front();
          check("write_addr", {26'd0, bus.mem_address}, {26'd0, w.a});
          check("write_data", {16'd0, bus.mem_in}, {16'd0, w.d});
          gold[w.a] = w.d;
        end
      end
    end
  end

  task automatic preload(input int a, input logic [WIDTH-1:0] v);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = AW'(a);
    pre_data = v;
    gold[a]  = v;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic run_cmd(input int s, input int d, input int l, input bit stray,
                         output int busy_cnt);
    int  n;
    bit  got_done;
    n = (l > DEPTH) ? DEPTH : l;
    model_cmd(s, d, l);
    @(negedge clk);
    bus.src   = AW'(s);
    bus.dst   = AW'(d);
    bus.len   = (AW+1)'(l);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = 0;
    got_done  = 1'b0;
    for (int c = 0; c < DEPTH * (RD_LAT + 2) + 10; c++) begin
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (stray && c == 2) begin
        bus.start = 1'b1;
        bus.src   = AW'($urandom_range(0, DEPTH-1));
        bus.dst   = AW'($urandom_range(0, DEPTH-1));
        bus.len   = (AW+1)'($urandom_range(1, DEPTH));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("done_seen", {31'd0, got_done}, 32'd1);
    check("busy_cycles", busy_cnt, n * (RD_LAT + 2));
    // A start during the DONE cycle must also be ignored.
    if (stray) begin
      bus.start = 1'b1;
      bus.len   = (AW+1)'($urandom_range(1, DEPTH));
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("idle_after_done", {31'd0, bus.busy}, 32'd0);
    check("writes_drained", exp_q.size(), 32'd0);
`ifdef RAM64_COPIER_CHECKSUM_EN
    check("checksum", {16'd0, bus.checksum}, {16'd0, exp_sum});
`endif
  endtask

  initial begin
    int               bc;
    logic [WIDTH-1:0] pre_dst [8];
    logic [WIDTH-1:0] pre_src [8];
    bit               timed_out;

    n_checks  = 0;
    n_errors  = 0;
    n_wr      = 0;
    bus.start = 1'b0;
    bus.src   = '0;
    bus.dst   = '0;
    bus.len   = '0;

    // Asynchronous reset takes effect before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_load", {31'd0, bus.mem_load}, 32'd0);
    check("rst_addr", {26'd0, bus.mem_address}, 32'd0);
    check("rst_in", {16'd0, bus.mem_in}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) preload(i, WIDTH'($urandom));

    // Basic four-word copy.
    preload(0, 16'h1111);
    preload(1, 16'h2222);
    preload(2, 16'h3333);
    preload(3, 16'h4444);
    run_cmd(0, 16, 4, 1'b0, bc);
    check("basic_busy_12", bc, 32'd12);
    check("basic_m16", {16'd0, tb_mem[16]}, 32'h1111);
    check("basic_m17", {16'd0, tb_mem[17]}, 32'h2222);
    check("basic_m18", {16'd0, tb_mem[18]}, 32'h3333);
    check("basic_m19", {16'd0, tb_mem[19]}, 32'h4444);
`ifdef RAM64_COPIER_CHECKSUM_EN
    check("basic_checksum", {16'd0, bus.checksum}, 32'hAAAA);
`endif

    // Zero-length command: done only, no memory traffic.
    bc = n_wr;
    run_cmd(5, 9, 0, 1'b0, bc);
    check("len0_busy", bc, 32'd0);

    // Source wraps from 63 to 0.
    preload(62, 16'h000A);
    preload(63, 16'h000B);
    preload(0,  16'h000C);
    run_cmd(62, 10, 3, 1'b0, bc);
    check("wrap_m10", {16'd0, tb_mem[10]}, 32'h000A);
    check("wrap_m11", {16'd0, tb_mem[11]}, 32'h000B);
    check("wrap_m12", {16'd0, tb_mem[12]}, 32'h000C);

    // Overlapping forward copy replicates the first word; stray starts ignored.
    preload(0, 16'hBEEF);
    run_cmd(0, 1, 3, 1'b1, bc);
    check("ovl_m1", {16'd0, tb_mem[1]}, 32'hBEEF);
    check("ovl_m2", {16'd0, tb_mem[2]}, 32'hBEEF);
    check("ovl_m3", {16'd0, tb_mem[3]}, 32'hBEEF);

    // Oversized length clamps to a full 64-word copy.
    run_cmd(3, 40, 127, 1'b0, bc);

    // Abort mid-transfer after two words.
    for (int i = 0; i < 8; i++) begin
      pre_src[i] = tb_mem[32 + i];
      pre_dst[i] = tb_mem[48 + i];
    end
    model_cmd(32, 48, 8);
    n_wr = 0;
    @(negedge clk);
    bus.src = 6'd32; bus.dst = 6'd48; bus.len = 7'd8; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (n_wr >= 2) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_2_writes", {31'd0, timed_out}, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_load", {31'd0, bus.mem_load}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_addr", {26'd0, bus.mem_address}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, bus.done}, 32'd0);
    end
    for (int i = 0; i < 8; i++)
      check("abort_dst", {16'd0, tb_mem[48 + i]}, {16'd0, (i < 2) ? pre_src[i] : pre_dst[i]});
    run_cmd(32, 48, 8, 1'b0, bc);

    // Randomized commands against the model.
    for (int t = 0; t < 25; t++)
      run_cmd($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
              $urandom_range(0, 70), 1'($urandom_range(0, 1)), bc);

    for (int i = 0; i < DEPTH; i++)
      check("final_mem", {16'd0, tb_mem[i]}, {16'd0, gold[i]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
